// File: rtl/boot_sequencer_pkg.sv
// Shared definitions for the boot sequencer: FSM state encodings and the tohost pass value.
package boot_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_LOAD_RD = 3'd1,
    S_LOAD_WR = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_e;

  localparam int unsigned PASS_CODE = 1;

  // Bits needed to count 0..max_val inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/boot_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/boot_sequencer.sv
// Bring-up controller: holds the core in reset, copies the boot ROM image into memory,
// releases the core and ends the run on a tohost store or when the tick budget runs out.
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 32,
  parameter logic [ADDR_W-1:0]  LOAD_BASE   = '0,
  parameter int                 LOAD_WORDS  = 1024,
  parameter int                 RST_CYCLES  = 2,
  parameter int                 MAX_TICKS   = 40,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR = 16'h3ff0,
  parameter int                 CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              core_rst,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  tick_count
);

  localparam int                RCW       = cnt_width(RST_CYCLES);
  localparam logic [RCW-1:0]    RST_LAST  = RCW'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'((LOAD_WORDS == 0) ? 0 : LOAD_WORDS - 1);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'((MAX_TICKS == 0) ? 0 : MAX_TICKS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] src_addr_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              core_rst_q;
  logic              done_q;
  logic              pass_q;
  logic              timeout_q;
  logic [DATA_W-1:0] exit_code_q;

  logic [RCW-1:0]    rst_cnt;
  logic [CNT_W-1:0]  tick_cnt;
  logic              rst_elapsed;
  logic              tohost_hit;
  logic              budget_hit;

  sat_counter #(.W(RCW)) u_rst_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (state_q == S_RESET),
    .cnt_o (rst_cnt)
  );

  // Counts every RUN cycle, including the one on which the run ends.
  sat_counter #(.W(CNT_W)) u_tick_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (state_q == S_RUN),
    .cnt_o (tick_cnt)
  );

  assign rst_elapsed = (rst_cnt == RST_LAST);
  assign tohost_hit  = bus_we && (bus_addr == TOHOST_ADDR);
  assign budget_hit  = (MAX_TICKS != 0) && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      idx_q       <= '0;
      src_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (rst_elapsed) begin
            if (LOAD_WORDS == 0) begin
              state_q    <= S_RUN;
              core_rst_q <= 1'b0;
            end else begin
              state_q    <= S_LOAD_RD;
              src_addr_q <= idx_q;
            end
          end
        end
        S_LOAD_RD: begin
          state_q     <= S_LOAD_WR;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= LOAD_BASE + idx_q;
          mem_wdata_q <= src_data;
        end
        // Write request and payload stay frozen until the memory accepts them.
        S_LOAD_WR: begin
          if (mem_ready) begin
            mem_we_q <= 1'b0;
            idx_q    <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q    <= S_RUN;
              core_rst_q <= 1'b0;
            end else begin
              state_q    <= S_LOAD_RD;
              src_addr_q <= idx_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (tohost_hit) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            pass_q      <= (bus_wdata == DATA_W'(PASS_CODE));
            exit_code_q <= bus_wdata;
            core_rst_q  <= 1'b1;
          end else if (budget_hit) begin
            state_q    <= S_TIMEOUT;
            done_q     <= 1'b1;
            timeout_q  <= 1'b1;
            core_rst_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign src_addr   = src_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst   = core_rst_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign exit_code  = exit_code_q;
  assign tick_count = tick_cnt;

endmodule
